fibo_bus_monitor: RTL and testbench
===================================

Name: fibo_bus_monitor

Overview:
- Passive receive-side endpoint on the shared Fibonacci bus. It samples the bus whenever a qualified send is active and checks each term against the Fibonacci recurrence.
- Accepted terms are buffered in a small FIFO that a downstream reader drains with a valid/ready handshake.
- Sits beside the two bus talkers; never drives the bus.

Parameters:
- WIDTH, 32, bus and term width in bits
- DEPTH, 8, FIFO entries (power of two, >= 2)
- CNT_W, 4, width of level and index counters (must hold DEPTH)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- bus_data  in  WIDTH  shared bus value (read only)
- bus_valid  in  1  high when exactly one talker drives the bus this cycle
- rd_ready  in  1  reader accepts head entry this cycle
- rd_valid  out  1  FIFO non-empty
- rd_data  out  WIDTH  FIFO head term
- level  out  CNT_W  current FIFO occupancy
- seq_error  out  1  sticky: a term broke the recurrence
- err_index  out  CNT_W  index of the first bad term (saturating)
- overflow  out  1  sticky: a term was dropped because the FIFO was full

Behaviour:
- Reset (rst low, async), all outputs low/zero:
  - FSM to S_SEED0; FIFO empty (rd_valid=0, level=0).
  - seq_error=0, err_index=0, overflow=0; prev=0, curr=0, term index=0.
- A sample is taken on every rising edge with bus_valid=1. bus_data is ignored when bus_valid=0.
- Checker FSM:
  - S_SEED0: sample -> prev=bus_data, index=1, go S_SEED1.
  - S_SEED1: sample -> curr=bus_data, index=2, go S_CHECK.
  - S_CHECK: sample compared to (prev+curr) mod 2^WIDTH.
    - On match: prev=curr, curr=bus_data, index+1 (saturates at all-ones).
    - On mismatch (first one only): seq_error=1, err_index=index.
    - Stay in S_CHECK and resynchronise: prev=curr, curr=bus_data, so later terms are checked against the observed stream.
  - No other transitions. Only reset returns the FSM to S_SEED0.
  - Unused state encoding -> S_SEED0.
- seq_error and err_index are sticky until reset. Later mismatches do not change err_index.
- Every sample, checked or seed, matching or not, is pushed into the FIFO.
- FIFO:
  - Push when bus_valid=1 and (not full, or pop in same cycle).
  - Pop when rd_valid=1 and rd_ready=1.
  - rd_data is the registered head, valid the same cycle rd_valid is high. First-word latency is 1 cycle after the push edge.
  - Simultaneous push and pop when full: both succeed, level unchanged, no overflow.
  - Simultaneous push and pop when empty: push only (rd_valid was 0), level becomes 1.
  - Push when full without pop: data dropped, overflow=1 (sticky), FSM/checker still advance.
  - Pop when empty: ignored, level stays 0.
  - Pointers wrap modulo DEPTH; level ranges 0..DEPTH.
- rd_ready asserted with rd_valid=0 has no effect.
- Reset mid-operation clears FIFO contents visibility (level=0) and the checker immediately. The next sample is treated as seed 0.

Test Plan:
- Reset then bus_valid pulses with 1,1,2,3,5,8 (rd_ready=0, DEPTH=8) -> level=6, seq_error=0; then rd_ready=1 for 6 cycles -> rd_data 1,1,2,3,5,8 in order, level returns 0, rd_valid drops.
- Stream 0,1,1,2,4,6 -> seq_error rises on the edge sampling 4, err_index=4; the value 6 matches (2+4) and err_index stays 4.
- Wrap-around: stream 0xFFFFFFFF,1,0 (WIDTH=32) -> 0 accepted as (0xFFFFFFFF+1) mod 2^32, seq_error=0.
- Fill 8 terms with rd_ready=0, send 9th term -> overflow=1, level=8; drain -> first 8 terms returned, 9th absent.
- With FIFO full, push and pop in the same cycle -> level stays 8, overflow stays 0, head advances by one.
- Drop rst for one half-cycle mid-stream after 4 terms -> level=0, rd_valid=0, seq_error=0 immediately (asynchronous). Next two samples re-seed; no error reported on them.

Source files
------------

// File: rtl/fibo_bus_monitor.sv
// Passive Fibonacci bus monitor: samples qualified bus terms, checks them
// against the Fibonacci recurrence and buffers every sample in a small FIFO
// drained by a valid/ready reader.
module fibo_bus_monitor #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] bus_data,
    input  logic             bus_valid,
    input  logic             rd_ready,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] level,
    output logic             seq_error,
    output logic [CNT_W-1:0] err_index,
    output logic             overflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] S_SEED0 = 2'd0;
    localparam logic [1:0] S_SEED1 = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;

    localparam logic [CNT_W-1:0] IDX_MAX  = '1;
    localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] curr_q, curr_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic             seq_err_q, seq_err_d;
    logic [CNT_W-1:0] err_idx_q, err_idx_d;
    logic             ovf_q, ovf_d;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] level_q, level_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] sum;
    logic [CNT_W-1:0] idx_inc;

    // A full FIFO still accepts a push when the reader frees a slot this cycle.
    always_comb begin
        full    = (level_q == FULL_LVL);
        empty   = (level_q == '0);
        pop     = !empty && rd_ready;
        push    = bus_valid && (!full || pop);
        sum     = prev_q + curr_q;
        idx_inc = (idx_q == IDX_MAX) ? idx_q : idx_q + 1'b1;
    end

    // Checker FSM: two seed terms, then every sample is compared to prev+curr
    // and the window always follows the observed stream.
    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        curr_d    = curr_q;
        idx_d     = idx_q;
        seq_err_d = seq_err_q;
        err_idx_d = err_idx_q;
        case (state_q)
            S_SEED0: begin
                if (bus_valid) begin
                    prev_d  = bus_data;
                    idx_d   = CNT_W'(1);
                    state_d = S_SEED1;
                end
            end
            S_SEED1: begin
                if (bus_valid) begin
                    curr_d  = bus_data;
                    idx_d   = CNT_W'(2);
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (bus_valid) begin
                    if ((bus_data != sum) && !seq_err_q) begin
                        seq_err_d = 1'b1;
                        err_idx_d = idx_q;
                    end
                    prev_d = curr_q;
                    curr_d = bus_data;
                    idx_d  = idx_inc;
                end
            end
            default: state_d = S_SEED0;
        endcase
    end

    // FIFO pointer, occupancy and sticky overflow next-state.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        ovf_d = ovf_q | (bus_valid && !push);
    end

    // Control and checker state, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_SEED0;
            prev_q    <= '0;
            curr_q    <= '0;
            idx_q     <= '0;
            seq_err_q <= 1'b0;
            err_idx_q <= '0;
            ovf_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            curr_q    <= curr_d;
            idx_q     <= idx_d;
            seq_err_q <= seq_err_d;
            err_idx_q <= err_idx_d;
            ovf_q     <= ovf_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
        end
    end

    // FIFO storage; contents need no reset since level gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus_data;
        end
    end

    assign rd_valid  = !empty;
    assign rd_data   = mem_q[rd_ptr_q];
    assign level     = level_q;
    assign seq_error = seq_err_q;
    assign err_index = err_idx_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_fibo_bus_monitor.sv
// Bench for fibo_bus_monitor: directed scenarios plus a randomized phase,
// compared each cycle against a queue-based reference model.
module tb_fibo_bus_monitor;

    localparam int WIDTH = 32;
    localparam int DEPTH = 8;
    localparam int CNT_W = 4;
    localparam int IDX_SAT = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [WIDTH-1:0] bus_data = '0;
    logic             bus_valid = 1'b0;
    logic             rd_ready = 1'b0;
    logic             rd_valid;
    logic [WIDTH-1:0] rd_data;
    logic [CNT_W-1:0] level;
    logic             seq_error;
    logic [CNT_W-1:0] err_index;
    logic             overflow;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] hist[$];
    bit               m_err;
    int               m_eidx;
    bit               m_ovf;

    fibo_bus_monitor #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus_data  (bus_data),
        .bus_valid (bus_valid),
        .rd_ready  (rd_ready),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .level     (level),
        .seq_error (seq_error),
        .err_index (err_index),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
            $error("%s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("level", 64'(level), 64'(mq.size()));
        chk("rd_valid", 64'(rd_valid), 64'(mq.size() > 0));
        if (mq.size() > 0) chk("rd_data", 64'(rd_data), 64'(mq[0]));
        chk("seq_error", 64'(seq_error), 64'(m_err));
        chk("err_index", 64'(err_index), 64'(m_eidx));
        chk("overflow", 64'(overflow), 64'(m_ovf));
    endtask

    // Recurrence check on the raw observed stream since reset.
    task automatic model_sample(input logic [WIDTH-1:0] d);
        int n;
        logic [WIDTH-1:0] s;
        n = hist.size();
        if (n >= 2) begin
            s = hist[n-1] + hist[n-2];
            if (d !== s && !m_err) begin
                m_err  = 1'b1;
                m_eidx = (n > IDX_SAT) ? IDX_SAT : n;
            end
        end
        hist.push_back(d);
    endtask

    task automatic model_reset();
        mq.delete();
        hist.delete();
        m_err  = 1'b0;
        m_eidx = 0;
        m_ovf  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus_valid = 1'b0;
        rd_ready  = 1'b0;
        rst       = 1'b0;
        model_reset();
        #1 check_outputs();
        #2 rst = 1'b1;
    endtask

    task automatic step(input bit bv, input logic [WIDTH-1:0] d, input bit rdy);
        bit p_pop, p_push;
        @(negedge clk);
        bus_valid = bv;
        bus_data  = d;
        rd_ready  = rdy;
        p_pop  = (mq.size() > 0) && rdy;
        p_push = bv && ((mq.size() < DEPTH) || p_pop);
        if (p_pop) void'(mq.pop_front());
        if (p_push) mq.push_back(d);
        else if (bv) m_ovf = 1'b1;
        if (bv) model_sample(d);
        @(posedge clk);
        #1 check_outputs();
    endtask

    function automatic logic [WIDTH-1:0] next_term();
        logic [WIDTH-1:0] s;
        if (hist.size() >= 2 && $urandom_range(0, 9) != 0)
            s = hist[hist.size()-1] + hist[hist.size()-2];
        else
            s = $urandom;
        return s;
    endfunction

    initial begin
        logic [WIDTH-1:0] fib[10];
        fib[0] = 1; fib[1] = 1;
        for (int i = 2; i < 10; i++) fib[i] = fib[i-1] + fib[i-2];

        // Basic fill and ordered drain
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, fib[i], 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);

        // First mismatch at index 4, later match keeps err_index
        do_reset();
        step(1'b1, 0, 1'b1); step(1'b1, 1, 1'b1); step(1'b1, 1, 1'b1);
        step(1'b1, 2, 1'b1); step(1'b1, 4, 1'b1); step(1'b1, 6, 1'b1);
        step(1'b1, 11, 1'b1);

        // Modular wrap-around of the sum
        do_reset();
        step(1'b1, 32'hFFFF_FFFF, 1'b0); step(1'b1, 1, 1'b0); step(1'b1, 0, 1'b0);
        step(1'b1, 1, 1'b0);

        // Overflow on ninth term, drain returns first eight
        do_reset();
        for (int i = 0; i < 9; i++) step(1'b1, fib[i], 1'b0);
        for (int i = 0; i < 9; i++) step(1'b0, '0, 1'b1);

        // Push and pop together while full
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, fib[i], 1'b0);
        step(1'b1, fib[8], 1'b1);
        step(1'b1, fib[9], 1'b1);
        for (int i = 0; i < 9; i++) step(1'b0, '0, 1'b1);

        // Empty pop ignored, empty push+pop pushes only
        do_reset();
        step(1'b0, '0, 1'b1);
        step(1'b1, 32'd5, 1'b1);

        // Asynchronous reset mid-stream, then re-seed
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, fib[i], 1'b0);
        do_reset();
        step(1'b1, 32'd7, 1'b0); step(1'b1, 32'd100, 1'b0); step(1'b1, 32'd107, 1'b0);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 149) == 0) do_reset();
            step($urandom_range(0, 3) != 0, next_term(), $urandom_range(0, 2) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
